ysyx_22040386_wbu: RTL and testbench
====================================

# ysyx_22040386_wbu

Writeback unit that drives the register file's single write port and tracks which destination registers still have results outstanding. It accepts results from the ALU path and the load/store path, arbitrates them onto one write per cycle, and keeps per-register pending counters. Decode uses these counters for RAW-hazard stalls. It sits between EXU/LSU and the register file and is the producer side of the register file's `wen/waddr/wdata` interface.

## Interface
- `ADDR_WIDTH`, 5, register index width (32 GPRs).
- `DATA_WIDTH`, 64, data width.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1; `alu_ready` out 1; `alu_rd` in ADDR_WIDTH; `alu_data` in DATA_WIDTH: ALU result channel.
- `lsu_valid` in 1; `lsu_ready` out 1; `lsu_rd` in ADDR_WIDTH; `lsu_data` in DATA_WIDTH: load-return channel.
- `alloc_valid` in 1; `alloc_ready` out 1; `alloc_rd` in ADDR_WIDTH: decode reserves a destination.
- `chk_rs1`, `chk_rs2` in ADDR_WIDTH: source indices to check.
- `busy_rs1`, `busy_rs2` out 1: source has an unwritten pending result.
- `rf_wen` out 1; `rf_waddr` out ADDR_WIDTH; `rf_wdata` out DATA_WIDTH: register file write port.
- `err_unalloc` out 1: sticky protocol error flag (see Configuration).

## Operation
- Handshakes use valid/ready. A transfer occurs on a rising edge where both are high. Producers hold `valid`/payload stable until the transfer.
- Arbitration uses fixed priority, LSU over ALU. `lsu_ready = 1` always. `alu_ready = !lsu_valid`. At most one result is accepted per cycle.
- The accepted result is registered into the output stage. In the next cycle `rf_wen=1`, with `rf_waddr`/`rf_wdata` set to the accepted rd/data. If nothing is accepted, `rf_wen=0`.
- rd==0: the result is accepted but `rf_wen` stays 0. `alloc_rd==0` is accepted and ignored. `busy_rsN` is always 0 for index 0.
- Scoreboard: each register 1..31 has a 2-bit pending counter `cnt[r]`, which allows up to 3 outstanding writes (WAW).
  - An alloc transfer increments `cnt[alloc_rd]`.
  - A result transfer decrements `cnt[rd]`.
  - An alloc and a result to the same rd on the same edge leave `cnt` unchanged.
  - A decrement at `cnt==0` leaves it at 0 (unallocated write). The write still commits.
- `alloc_ready = (cnt[alloc_rd] != 3)`. This is combinational from `alloc_rd`.
- `busy_rsN = (chk_rsN!=0) && (cnt[chk_rsN]!=0 || (rf_wen && rf_waddr==chk_rsN))`. The in-flight output stage therefore still reports busy until the write commits.

## Timing
- Reset (async assert, state cleared immediately):
  - `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`.
  - All `cnt=0`, `err_unalloc=0`.
  - Combinational outputs reflect this: `busy_rs*=0`, `alloc_ready=1`, `lsu_ready=1`, and `alu_ready=!lsu_valid`.
- Deassertion is sampled synchronously; the first transfer can occur on the first rising edge with `rst_n=1`.
- Result latency is exactly 1 cycle: accepted at edge N, `rf_wen` high during cycle N+1, and the register file commits at edge N+1.
- Throughput is 1 write/cycle sustained, with no bubbles between back-to-back transfers.
- A register is busy from the cycle after its alloc edge through the cycle `rf_wen` presents it. `busy` falls in the cycle after the register file commit edge.
- Reset mid-operation discards the output stage (no write issued) and clears all counters.

## Configuration
- `YSYX_22040386_WB_CHECK_EN` defined:
  - `err_unalloc` is set on any result transfer with rd≠0 and `cnt[rd]==0` (with no same-edge alloc to that rd).
  - The flag is sticky until reset.
  - A `$display` warning prints the rd and cycle.
- Macro undefined: `err_unalloc` is tied to 0 and the check logic is not built.

## Test plan
- Reset, then ALU transfer rd=5, data=0xDEAD_BEEF -> next cycle `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`. The following idle cycle has `rf_wen=0`.
- ALU and LSU both valid (rd=3 and rd=4) -> LSU (rd=4) is written first and `alu_ready=0`. ALU rd=3 is written in the following cycle.
- Alloc rd=7 three times -> `alloc_ready=0` for rd=7. After one result to rd=7, `alloc_ready=1`. `busy_rs1` with `chk_rs1=7` stays 1 until the third write commits.
- Same-edge alloc rd=9 and result rd=9 with `cnt[9]=1` -> `cnt[9]` stays 1 and `busy` stays high.
- Result rd=0 and alloc rd=0 -> no `rf_wen`, and `busy_rs*` for index 0 stays 0.
- With `YSYX_22040386_WB_CHECK_EN`: result to unallocated rd=12 -> `err_unalloc=1` and it holds until `rst_n=0`. During reset, while the output stage is full, `rf_wen` drops to 0 immediately.

Source files
------------

// File: rtl/ysyx_22040386_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_22040386_wbu -- writeback unit
//
// Accepts results from the LSU (load return) and ALU channels, picks one per
// cycle (LSU wins), and registers it into a single output stage that drives
// the register file write port one cycle later. It also keeps a 2-bit
// pending-write counter per GPR. Decode uses these counters for RAW stalls.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   alu_valid/ready/rd/data           ALU result channel
//   lsu_valid/ready/rd/data           load-return channel (always ready)
//   alloc_valid/ready/rd              decode reserves a destination register
//   chk_rs1/2, busy_rs1/2             RAW query: source still has a pending write
//   rf_wen/waddr/wdata                register file write port (registered)
//   err_unalloc                       sticky "write to unallocated rd" flag
//
// Optional feature: define YSYX_22040386_WB_CHECK_EN to build the
// unallocated-write checker. Without it, err_unalloc is tied low.
// ---------------------------------------------------------------------------
module ysyx_22040386_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [ADDR_WIDTH-1:0] alloc_rd,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  err_unalloc
);

    localparam int NREG = 1 << ADDR_WIDTH;

    // Accepted result this cycle. The LSU is always ready, so the ALU only
    // transfers when the LSU is idle, and at most one result is accepted.
    logic                  acc_valid;
    logic [ADDR_WIDTH-1:0] acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  alloc_fire;

    assign lsu_ready = 1'b1;
    assign alu_ready = !lsu_valid;
    assign acc_valid = lsu_valid | alu_valid;
    assign acc_rd    = lsu_valid ? lsu_rd   : alu_rd;
    assign acc_data  = lsu_valid ? lsu_data : alu_data;

    // Pending-write scoreboard
    logic [1:0] cnt_reg  [NREG];
    logic [1:0] cnt_next [NREG];

    // Saturation at 3 is enforced by back-pressuring alloc, not by clamping.
    assign alloc_ready = (cnt_reg[alloc_rd] != 2'd3);
    assign alloc_fire  = alloc_valid && alloc_ready;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                // x0 never has pending writes
                assign cnt_next[gi] = 2'd0;
            end else begin : g_reg
                logic inc;
                logic dec;
                assign inc = alloc_fire && (alloc_rd == ADDR_WIDTH'(gi));
                assign dec = acc_valid  && (acc_rd   == ADDR_WIDTH'(gi));
                // Same-edge alloc+result cancel; a result at cnt==0 is an
                // unallocated write that still commits but leaves cnt at 0.
                assign cnt_next[gi] = (inc && !dec) ? cnt_reg[gi] + 2'd1 :
                                      (dec && !inc && cnt_reg[gi] != 2'd0) ? cnt_reg[gi] - 2'd1 :
                                      cnt_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_reg[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_reg[i] <= cnt_next[i];
        end
    end

    // Output stage: one-cycle latency to the register file.
    logic                  rf_wen_reg;
    logic [ADDR_WIDTH-1:0] rf_waddr_reg;
    logic [DATA_WIDTH-1:0] rf_wdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_reg   <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else begin
            // rd==0 results are consumed but never written.
            rf_wen_reg <= acc_valid && (acc_rd != '0);
            if (acc_valid) begin
                rf_waddr_reg <= acc_rd;
                rf_wdata_reg <= acc_data;
            end
        end
    end

    assign rf_wen   = rf_wen_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;

    // The counter drops at acceptance, so the in-flight output stage must also
    // report busy until the register file has actually committed the value.
    assign busy_rs1 = (chk_rs1 != '0) &&
                      ((cnt_reg[chk_rs1] != 2'd0) || (rf_wen_reg && rf_waddr_reg == chk_rs1));
    assign busy_rs2 = (chk_rs2 != '0) &&
                      ((cnt_reg[chk_rs2] != 2'd0) || (rf_wen_reg && rf_waddr_reg == chk_rs2));

`ifdef YSYX_22040386_WB_CHECK_EN
    logic unalloc_hit;
    logic err_reg;

    assign unalloc_hit = acc_valid && (acc_rd != '0) && (cnt_reg[acc_rd] == 2'd0) &&
                         !(alloc_fire && alloc_rd == acc_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (unalloc_hit) begin
            err_reg <= 1'b1;
        end
    end

    assign err_unalloc = err_reg;

`ifndef SYNTHESIS
    logic [63:0] cyc_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_reg <= '0;
        end else begin
            cyc_reg <= cyc_reg + 64'd1;
            if (unalloc_hit)
                $display("wbu warning: write to unallocated rd=%0d at cycle %0d", acc_rd, cyc_reg);
        end
    end
`endif
`else
    assign err_unalloc = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040386_wbu.sv
module tb_ysyx_22040386_wbu;
    localparam int AW = 5;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [AW-1:0] alu_rd, lsu_rd, alloc_rd, chk_rs1, chk_rs2, rf_waddr;
    logic [DW-1:0] alu_data, lsu_data, rf_wdata;
    logic          alloc_valid, alloc_ready, busy_rs1, busy_rs2, rf_wen, err_unalloc;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected register-file writes {addr, data}
    logic [AW+DW-1:0] exp_q [$];

    ysyx_22040386_wbu #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err_unalloc(err_unalloc)
    );

    always #5 clk = ~clk;

`ifdef YSYX_22040386_WB_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    // Reference model of the arbiter: LSU wins, rd==0 produces no write.
    always @(posedge clk) begin
        if (rst_n) begin
            if (lsu_valid) begin
                if (lsu_rd != 0) exp_q.push_back({lsu_rd, lsu_data});
            end else if (alu_valid) begin
                if (alu_rd != 0) exp_q.push_back({alu_rd, alu_data});
            end
        end
    end

    // Every presented write must match the oldest expected write.
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (rst_n && rf_wen) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got write rd=%0d data=%h, expected none", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    errors++;
                    $display("FAIL sb_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                             rf_waddr, rf_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                end else begin
                    $display("write rd=%0d data=%h ok", rf_waddr, rf_wdata);
                end
            end
        end
    end

    task automatic set_idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        alloc_valid = 0; alloc_rd = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; set_idle(); chk_rs1 = 5; chk_rs2 = 7;
        #2;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b expected 0", rf_wen); end
        checks++; if (rf_waddr !== '0) begin errors++; $display("FAIL rst_waddr: got %0d expected 0", rf_waddr); end
        checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %h expected 0", rf_wdata); end
        checks++; if ({busy_rs1, busy_rs2} !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b expected 00", {busy_rs1, busy_rs2}); end
        checks++; if ({alloc_ready, lsu_ready, alu_ready} !== 3'b111) begin errors++; $display("FAIL rst_ready: got %b expected 111", {alloc_ready, lsu_ready, alu_ready}); end
        checks++; if (err_unalloc !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err_unalloc); end
        lsu_valid = 1; #1;
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %b expected 0", alu_ready); end
        lsu_valid = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
        $display("reset done");
    endtask

    task automatic test_alu_basic();
        @(negedge clk);
        alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD_BEEF;
        @(negedge clk);
        set_idle();
        checks++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd5} || rf_wdata !== 64'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_basic: got wen=%b rd=%0d data=%h expected 1/5/deadbeef", rf_wen, rf_waddr, rf_wdata); end
        @(negedge clk);
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL alu_idle: got wen=%b expected 0", rf_wen); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        alu_valid = 1; alu_rd = 3; alu_data = 64'h3333;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 64'h4444;
        #1;
        checks++; if ({alu_ready, lsu_ready} !== 2'b01) begin errors++; $display("FAIL prio_ready: got alu=%b lsu=%b expected 0/1", alu_ready, lsu_ready); end
        @(negedge clk);
        lsu_valid = 0;
        checks++; if (rf_waddr !== 5'd4) begin errors++; $display("FAIL prio_first: got rd=%0d expected 4", rf_waddr); end
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL prio_alu_ready: got %b expected 1", alu_ready); end
        @(negedge clk);
        set_idle();
        checks++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd3}) begin errors++; $display("FAIL prio_second: got wen=%b rd=%0d expected 1/3", rf_wen, rf_waddr); end
    endtask

    task automatic test_waw();
        chk_rs1 = 7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alloc_valid = 1; alloc_rd = 7; #1;
            checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL waw_alloc%0d: got ready=%b expected 1", i, alloc_ready); end
        end
        @(negedge clk); #1;   // fourth attempt must be refused
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL waw_full: got ready=%b expected 0", alloc_ready); end
        checks++; if (busy_rs1 !== 1'b1) begin errors++; $display("FAIL waw_busy: got %b expected 1", busy_rs1); end
        // three back-to-back results to rd7
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alloc_valid = 0; alloc_rd = 7;
            if (i == 1) begin
                #1; checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL waw_ready_after1: got %b expected 1", alloc_ready); end
            end
            if (i > 0) begin
                checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL waw_b2b%0d: got wen=%b expected 1", i, rf_wen); end
            end
            alu_valid = 1; alu_rd = 7; alu_data = 64'h7000 + 64'(i);
            #1;
            checks++; if (busy_rs1 !== 1'b1) begin errors++; $display("FAIL waw_busy_pend%0d: got %b expected 1", i, busy_rs1); end
        end
        @(negedge clk);
        set_idle(); #1;
        checks++; if ({rf_wen, busy_rs1} !== 2'b11) begin errors++; $display("FAIL waw_busy_inflight: got wen=%b busy=%b expected 1/1", rf_wen, busy_rs1); end
        @(negedge clk); #1;
        checks++; if (busy_rs1 !== 1'b0) begin errors++; $display("FAIL waw_busy_clear: got %b expected 0", busy_rs1); end
    endtask

    task automatic test_same_edge();
        chk_rs2 = 9;
        @(negedge clk);
        alloc_valid = 1; alloc_rd = 9;
        @(negedge clk);
        alu_valid = 1; alu_rd = 9; alu_data = 64'h9999;   // cnt[9]=1, alloc+result together
        @(negedge clk);
        set_idle();
        @(negedge clk); @(negedge clk); #1;
        checks++; if (busy_rs2 !== 1'b1) begin errors++; $display("FAIL same_busy: got %b expected 1", busy_rs2); end
        @(negedge clk);
        alu_valid = 1; alu_rd = 9; alu_data = 64'h9998;   // drains the single pending write
        @(negedge clk);
        set_idle();
        @(negedge clk); #1;
        checks++; if (busy_rs2 !== 1'b0) begin errors++; $display("FAIL same_drain: got %b expected 0", busy_rs2); end
    endtask

    task automatic test_zero();
        chk_rs1 = 0; chk_rs2 = 0;
        @(negedge clk);
        alu_valid = 1; alu_rd = 0; alu_data = 64'hF00D;
        alloc_valid = 1; alloc_rd = 0;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL zero_alloc_ready: got %b expected 1", alloc_ready); end
        @(negedge clk);
        set_idle(); #1;
        checks++; if ({rf_wen, busy_rs1, busy_rs2} !== 3'b000) begin errors++; $display("FAIL zero_nowrite: got wen=%b busy=%b%b expected 000", rf_wen, busy_rs1, busy_rs2); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = AW'($urandom_range(0, 31)); lsu_data = {$urandom, $urandom};
            alu_valid = 1'($urandom_range(0, 3) != 0); alu_rd = AW'($urandom_range(0, 31)); alu_data = {$urandom, $urandom};
            #1;
            checks++; if (alu_ready !== !lsu_valid) begin errors++; $display("FAIL b2b_alu_ready%0d: got %b expected %b", i, alu_ready, !lsu_valid); end
        end
        @(negedge clk);
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        exp_q.delete();
        chk_rs1 = 11;
        alloc_valid = 1; alloc_rd = 11;
        @(negedge clk);
        set_idle();
        alu_valid = 1; alu_rd = 12; alu_data = 64'hC0DE;  // rd12 never allocated
        @(negedge clk);
        set_idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (err_unalloc !== ERR_EXP) begin errors++; $display("FAIL err_unalloc%0d: got %b expected %b", i, err_unalloc, ERR_EXP); end
            @(negedge clk);
        end
        alu_valid = 1; alu_rd = 10; alu_data = 64'hAAAA;
        @(posedge clk); #1;
        set_idle();
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL mrst_full: got wen=%b expected 1", rf_wen); end
        rst_n = 0; #1;
        exp_q.delete();   // the in-flight write is discarded by reset
        checks++; if ({rf_wen, busy_rs1, err_unalloc} !== 3'b000) begin
            errors++; $display("FAIL mrst_clear: got wen=%b busy=%b err=%b expected 000", rf_wen, busy_rs1, err_unalloc); end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL mrst_nowrite: got wen=%b expected 0", rf_wen); end
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_priority();
        test_waw();
        test_same_edge();
        test_zero();
        test_back_to_back();
        test_mid_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending writes expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
